// File: rtl/bv_and_pipe_if.sv
// ----------------------------------------------------------------------------
// bv_and_pipe_if
// Stream bundle between the per-field lookup clusters, the bit-vector
// combiner and the action lookup.
//   in_valid / in_ready / bv_in              : field vectors into the combiner
//   out_valid / out_ready / bv_out / hit /
//   match_idx                                : combined rule vector out
// Modports:
//   master : the side that supplies field vectors and consumes results
//   slave  : the combiner itself
// ----------------------------------------------------------------------------
interface bv_and_pipe_if #(
   parameter int FIELD_N = 8,
   parameter int BV_W    = 36,
   parameter int IDX_W   = 6
);
   logic                      in_valid;
   logic                      in_ready;
   logic [FIELD_N*BV_W-1:0]   bv_in;
   logic                      out_valid;
   logic                      out_ready;
   logic [BV_W-1:0]           bv_out;
   logic                      hit;
   logic [IDX_W-1:0]          match_idx;

   modport master (
      output in_valid, bv_in, out_ready,
      input  in_ready, out_valid, bv_out, hit, match_idx
   );

   modport slave (
      input  in_valid, bv_in, out_ready,
      output in_ready, out_valid, bv_out, hit, match_idx
   );
endinterface

// File: rtl/bv_and_pipe.sv
// ----------------------------------------------------------------------------
// bv_and_pipe
// Combines FIELD_N per-field match bit vectors into one rule vector by AND,
// with per-field wildcarding, a 3-stage valid/ready pipeline, lowest-index
// match encoding and saturating hit/miss statistics.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low reset
//   field_en  : bit i = 0 wildcards field i (treated as all ones)
//   stat_clr  : synchronous clear of hit_cnt and miss_cnt
//   hit_cnt   : delivered results with hit = 1, saturating
//   miss_cnt  : delivered results with hit = 0, saturating
//   bus       : slave side of bv_and_pipe_if (input stream, result stream)
// ----------------------------------------------------------------------------
module bv_and_pipe #(
   parameter int FIELD_N = 8,
   parameter int BV_W    = 36,
   parameter int IDX_W   = 6,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FIELD_N-1:0] field_en,
   input  logic               stat_clr,
   output logic [CNT_W-1:0]   hit_cnt,
   output logic [CNT_W-1:0]   miss_cnt,
   bv_and_pipe_if.slave       bus
);

   logic                          adv;
   logic                          s1_valid;
   logic [FIELD_N-1:0][BV_W-1:0]  s1_m;
   logic [FIELD_N-1:0][BV_W-1:0]  masked;
   logic                          s2_valid;
   logic [BV_W-1:0]               s2_r;
   logic [BV_W-1:0]               and_r;
   logic [IDX_W-1:0]              low_idx;
   logic                          out_valid;
   logic [BV_W-1:0]               bv_out;
   logic                          hit;
   logic [IDX_W-1:0]              match_idx;
   logic                          out_xfer;

   // The whole pipeline moves together; a stalled output freezes every stage.
   assign adv          = !out_valid || bus.out_ready;
   assign bus.in_ready = adv;
   assign out_xfer     = out_valid && bus.out_ready;

   assign bus.out_valid = out_valid;
   assign bus.bv_out    = bv_out;
   assign bus.hit       = hit;
   assign bus.match_idx = match_idx;

   // Wildcarded fields become all ones so they drop out of the AND.
   always_comb begin
      masked = '0;
      for (int i = 0; i < FIELD_N; i++) begin
         masked[i] = field_en[i] ? bus.bv_in[i*BV_W +: BV_W] : {BV_W{1'b1}};
      end
   end

   // Stage 1: register the masked field vectors at the transfer cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_m     <= '0;
      end else if (adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_m <= masked;
         end
      end
   end

   always_comb begin
      and_r = {BV_W{1'b1}};
      for (int i = 0; i < FIELD_N; i++) begin
         and_r = and_r & s1_m[i];
      end
   end

   // Stage 2: register the combined rule vector.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_r     <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_r <= and_r;
         end
      end
   end

   // Scan from the top down so the lowest set bit wins; 0 when nothing matches.
   always_comb begin
      low_idx = '0;
      for (int i = BV_W - 1; i >= 0; i--) begin
         if (s2_r[i]) begin
            low_idx = IDX_W'(i);
         end
      end
   end

   // Stage 3: output register, held while downstream is not ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         bv_out    <= '0;
         hit       <= 1'b0;
         match_idx <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            bv_out    <= s2_r;
            hit       <= |s2_r;
            match_idx <= low_idx;
         end
      end
   end

   // Statistics: clear beats a same-cycle increment; both saturate at all ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (stat_clr) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (out_xfer) begin
         if (hit) begin
            if (hit_cnt != {CNT_W{1'b1}}) begin
               hit_cnt <= hit_cnt + 1'b1;
            end
         end else begin
            if (miss_cnt != {CNT_W{1'b1}}) begin
               miss_cnt <= miss_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bv_and_pipe.sv
// ----------------------------------------------------------------------------
// tb_bv_and_pipe
// Directed-vector scoreboard bench for bv_and_pipe (CNT_W = 4 so that
// saturation is reachable). The driver pushes hand-computed expectations on
// each input transfer; a negedge monitor pops and compares on each output
// transfer and keeps a model of the statistics counters.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bv_and_pipe;

   localparam int FN = 8;
   localparam int BW = 36;
   localparam int IW = 6;
   localparam int CW = 4;

   typedef struct {
      logic [BW-1:0] bv;
      logic          hit;
      logic [IW-1:0] idx;
      bit            chkLat;
      int            inCycle;
   } exp_t;

   logic           clk;
   logic           reset;
   logic [FN-1:0]  field_en;
   logic           stat_clr;
   logic [CW-1:0]  hit_cnt;
   logic [CW-1:0]  miss_cnt;

   bv_and_pipe_if #(.FIELD_N(FN), .BV_W(BW), .IDX_W(IW)) bus ();

   bv_and_pipe #(.FIELD_N(FN), .BV_W(BW), .IDX_W(IW), .CNT_W(CW)) dut (
      .clk      (clk),
      .reset    (reset),
      .field_en (field_en),
      .stat_clr (stat_clr),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt),
      .bus      (bus)
   );

   exp_t sb[$];
   int   nChecks = 0;
   int   nPass = 0;
   int   cyc = 0;
   int   nDelivered = 0;
   int   mHit = 0;
   int   mMiss = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, ".hit_cnt"}, 64'(hit_cnt), 64'(mHit));
      checkOutput({tag, ".miss_cnt"}, 64'(miss_cnt), 64'(mMiss));
   endtask

   // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
   task automatic applyStimulus(input logic [FN-1:0] en, input logic [FN*BW-1:0] vec,
                                input logic [BW-1:0] expBv, input logic expHit,
                                input logic [IW-1:0] expIdx, input bit chkLat);
      exp_t e;
      bit   done;
      done = 0;
      field_en     = en;
      bus.bv_in    = vec;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            e.bv = expBv; e.hit = expHit; e.idx = expIdx;
            e.chkLat = chkLat; e.inCycle = cyc;
            sb.push_back(e);
            done = 1;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!done) checkOutput("inputAcceptTimeout", 64'd0, 64'd1);
   endtask

   task automatic waitDrain(input string tag);
      bit ok;
      ok = 0;
      for (int t = 0; t < 60 && !ok; t++) begin
         @(posedge clk); #1;
         if (sb.size() == 0) ok = 1;
      end
      if (!ok) checkOutput({tag, ".drainTimeout"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic waitOutValid(input string tag);
      bit ok;
      ok = 0;
      for (int t = 0; t < 30 && !ok; t++) begin
         @(negedge clk);
         if (bus.out_valid) ok = 1;
      end
      if (!ok) checkOutput({tag, ".outValidTimeout"}, 64'd0, 64'd1);
   endtask

   // Monitor: compare every delivered result against the scoreboard front.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset) begin
         if (bus.out_valid && bus.out_ready) begin
            nDelivered++;
            if (sb.size() == 0) begin
               checkOutput("unexpectedOutput", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("bv_out", 64'(bus.bv_out), 64'(e.bv));
               checkOutput("hit", 64'(bus.hit), 64'(e.hit));
               checkOutput("match_idx", 64'(bus.match_idx), 64'(e.idx));
               if (e.chkLat) checkOutput("latency", 64'(cyc - e.inCycle), 64'd3);
               if (!stat_clr) begin
                  if (e.hit) begin
                     if (mHit != 15) mHit++;
                  end else begin
                     if (mMiss != 15) mMiss++;
                  end
               end
            end
         end
         if (stat_clr) begin
            mHit = 0;
            mMiss = 0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      logic [FN*BW-1:0] v;
      logic [FN*BW-1:0] ones;
      int               d0;
      ones         = {FN{36'hF_FFFF_FFFF}};
      reset        = 1'b0;
      field_en     = 8'hFF;
      stat_clr     = 1'b0;
      bus.in_valid = 1'b0;
      bus.bv_in    = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset.out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset.bv_out", 64'(bus.bv_out), 64'd0);
      checkOutput("reset.hit", 64'(bus.hit), 64'd0);
      checkOutput("reset.match_idx", 64'(bus.match_idx), 64'd0);
      checkOutput("reset.hit_cnt", 64'(hit_cnt), 64'd0);
      checkOutput("reset.miss_cnt", 64'(miss_cnt), 64'd0);
      checkOutput("reset.in_ready", 64'(bus.in_ready), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;

      // 1: single hit on bit 4 via field 3
      $display("[TB] test 1: single beat");
      v = ones;
      v[3*BW +: BW] = 36'h0_0000_0010;
      applyStimulus(8'hFF, v, 36'h0_0000_0010, 1'b1, 6'd4, 1'b1);
      waitDrain("t1");
      checkOutput("t1.hit_cnt", 64'(hit_cnt), 64'd1);

      // 2: wildcards, top-bit boundary, mixed fields
      $display("[TB] test 2: wildcards");
      v = {{4{36'h0}}, {4{36'h8_0000_0001}}};
      applyStimulus(8'h0F, v, 36'h8_0000_0001, 1'b1, 6'd0, 1'b1);
      applyStimulus(8'h00, v, 36'hF_FFFF_FFFF, 1'b1, 6'd0, 1'b1);
      v = '0;
      v[7*BW +: BW] = 36'h8_0000_0000;
      applyStimulus(8'h80, v, 36'h8_0000_0000, 1'b1, 6'd35, 1'b1);
      v = '0;
      v[1*BW +: BW] = 36'h0_0000_F0F0;
      v[2*BW +: BW] = 36'h0_0000_FF00;
      applyStimulus(8'h06, v, 36'h0_0000_F000, 1'b1, 6'd12, 1'b1);
      waitDrain("t2");

      // 3: disjoint fields produce a miss
      $display("[TB] test 3: miss");
      v = ones;
      v[0*BW +: BW] = 36'h1;
      v[1*BW +: BW] = 36'h2;
      applyStimulus(8'hFF, v, 36'h0, 1'b0, 6'd0, 1'b1);
      waitDrain("t3");
      checkCounters("t3");
      checkOutput("t3.miss_cnt", 64'(miss_cnt), 64'd1);

      // 4: five beats with a 4-cycle output stall
      $display("[TB] test 4: stall");
      d0 = nDelivered;
      bus.out_ready = 1'b0;
      fork
         begin
            for (int k = 1; k <= 5; k++) begin
               v = ones;
               v[5*BW +: BW] = 36'(1) << k;
               applyStimulus(8'hFF, v, 36'(1) << k, 1'b1, IW'(k), 1'b0);
            end
         end
         begin
            waitOutValid("t4");
            for (int s = 0; s < 4; s++) begin
               if (s > 0) @(negedge clk);
               checkOutput("t4.stall.in_ready", 64'(bus.in_ready), 64'd0);
               checkOutput("t4.stall.out_valid", 64'(bus.out_valid), 64'd1);
               checkOutput("t4.stall.bv_out", 64'(bus.bv_out), 64'h2);
               checkOutput("t4.stall.match_idx", 64'(bus.match_idx), 64'd1);
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
         end
      join
      waitDrain("t4");
      checkOutput("t4.delivered", 64'(nDelivered - d0), 64'd5);
      checkCounters("t4");

      // 5: saturation, then clear colliding with a transfer
      $display("[TB] test 5: saturation and clear");
      stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
      checkOutput("t5.cleared", 64'(hit_cnt), 64'd0);
      v = ones;
      for (int k = 0; k < 16; k++) begin
         applyStimulus(8'hFF, v, 36'hF_FFFF_FFFF, 1'b1, 6'd0, 1'b0);
      end
      waitDrain("t5");
      checkOutput("t5.hitSat", 64'(hit_cnt), 64'hF);
      checkCounters("t5");
      bus.out_ready = 1'b0;
      applyStimulus(8'hFF, v, 36'hF_FFFF_FFFF, 1'b1, 6'd0, 1'b0);
      waitOutValid("t5");
      @(posedge clk); #1;
      stat_clr = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
      checkOutput("t5.clrHit", 64'(hit_cnt), 64'd0);
      checkOutput("t5.clrMiss", 64'(miss_cnt), 64'd0);
      checkOutput("t5.clrDrained", 64'(sb.size()), 64'd0);

      // 6: reset with three beats in flight
      $display("[TB] test 6: reset mid-flight");
      v = ones;
      v[0*BW +: BW] = 36'h1;
      v[1*BW +: BW] = 36'h2;
      applyStimulus(8'hFF, v, 36'h0, 1'b0, 6'd0, 1'b1);
      waitDrain("t6a");
      checkOutput("t6.missBefore", 64'(miss_cnt), 64'd1);
      bus.out_ready = 1'b0;
      v = ones;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(8'hFF, v, 36'hF_FFFF_FFFF, 1'b1, 6'd0, 1'b0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      mHit = 0;
      mMiss = 0;
      #1;
      checkOutput("t6.out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("t6.hit_cnt", 64'(hit_cnt), 64'd0);
      checkOutput("t6.miss_cnt", 64'(miss_cnt), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      bus.out_ready = 1'b1;
      d0 = nDelivered;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("t6.noOutput", 64'(nDelivered - d0), 64'd0);
      v = ones;
      v[6*BW +: BW] = 36'h0_4000_0000;
      applyStimulus(8'hFF, v, 36'h0_4000_0000, 1'b1, 6'd30, 1'b1);
      waitDrain("t6b");
      checkCounters("t6");

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
